jailbreak_hs_ctrl: RTL and testbench

//  Sequences high-score RAM accesses against the running Jailbreak core.

---
 rtl/jailbreak_hs_ctrl_pkg.sv | 32 +++
 rtl/jailbreak_hs_ctrl.sv | 136 +++++++++++++
 tb/tb_jailbreak_hs_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jailbreak_hs_ctrl_pkg.sv
// Shared types for the Jailbreak high-score access sequencer.
// Holds the FSM state enum, the latched request struct and the counter sizing helper.
package jailbreak_hs_ctrl_pkg;

    localparam int HS_ADDR_W = 12;
    localparam int HS_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCESS,
        ST_RDWAIT,
        ST_RESP,
        ST_HOLD
    } hs_state_e;

    typedef struct packed {
        logic                 write;
        logic [HS_ADDR_W-1:0] addr;
        logic [HS_DATA_W-1:0] wdata;
    } hs_req_t;

    // The counter only ever holds (max - 1), so $clog2(max) bits suffice.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/jailbreak_hs_ctrl.sv
// Halts the Jailbreak CPU, lets the halt settle, then performs one hs_* byte access
// per request; the halt is kept across bursts until HOLD_CYCLES idle cycles pass.
//
//  state  | meaning
//  IDLE   | CPU running, waiting for a request
//  SETTLE | halt asserted, waiting for the core to pause
//  ACCESS | one cycle driving hs_* (write strobe here)
//  RDWAIT | address held until hs_data_out is valid
//  RESP   | one-cycle response pulse
//  HOLD   | halt kept, next request skips the settle
module jailbreak_hs_ctrl
    import jailbreak_hs_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = HS_ADDR_W,
    parameter int DATA_WIDTH    = HS_DATA_W,
    parameter int HS_SIZE       = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int READ_LATENCY  = 2,
    parameter int HOLD_CYCLES   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  processor_halt,
    output logic                  hs_access_write,
    output logic [ADDR_WIDTH-1:0] hs_address,
    output logic [DATA_WIDTH-1:0] hs_data_in,
    output logic                  hs_write_enable,
    input  logic [DATA_WIDTH-1:0] hs_data_out
);

    localparam int CW = cnt_width(SETTLE_CYCLES, READ_LATENCY, HOLD_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] RDLAT_LOAD  = (READ_LATENCY > 0)  ? CW'(READ_LATENCY - 1)  : '0;
    localparam logic [CW-1:0] HOLD_LOAD   = (HOLD_CYCLES > 0)   ? CW'(HOLD_CYCLES - 1)   : '0;
    localparam bit            NO_REJECT   = (HS_SIZE >= (1 << ADDR_WIDTH));

    hs_state_e             state_q, state_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    hs_req_t               req_q, req_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic                  handshake;
    logic                  in_range;
    logic                  access;

    assign in_range  = NO_REJECT ||
                       ({{(32-HS_ADDR_W){1'b0}}, req_q.addr} < 32'(HS_SIZE));
    assign req_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign handshake = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            req_q   <= req_n;
            rdata_q <= rdata_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        req_n   = req_q;
        rdata_n = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_n = ST_SETTLE;
                    cnt_n   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_n = ST_ACCESS;
                else             cnt_n   = cnt_q - CW'(1);
            end
            ST_ACCESS: begin
                if (!in_range || req_q.write) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_RDWAIT;
                    cnt_n   = RDLAT_LOAD;
                end
            end
            ST_RDWAIT: begin
                if (cnt_q == '0) begin
                    state_n = ST_RESP;
                    rdata_n = hs_data_out;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_HOLD;
                cnt_n   = HOLD_LOAD;
            end
            ST_HOLD: begin
                if (handshake)             state_n = ST_ACCESS;
                else if (cnt_q == '0)      state_n = ST_IDLE;
                else                       cnt_n   = cnt_q - CW'(1);
            end
            default: state_n = ST_IDLE;
        endcase

        // Clearing rdata here keeps write/error responses at zero.
        if (handshake) begin
            req_n   = '{write: req_write,
                        addr:  HS_ADDR_W'(req_addr),
                        wdata: HS_DATA_W'(req_wdata)};
            rdata_n = '0;
        end
    end

    assign access          = ((state_q == ST_ACCESS) && in_range) || (state_q == ST_RDWAIT);
    assign processor_halt  = (state_q != ST_IDLE);
    assign hs_access_write = access;
    assign hs_address      = access ? ADDR_WIDTH'(req_q.addr) : '0;
    assign hs_write_enable = (state_q == ST_ACCESS) && in_range && req_q.write;
    assign hs_data_in      = hs_write_enable ? DATA_WIDTH'(req_q.wdata) : '0;
    assign rsp_valid       = (state_q == ST_RESP);
    assign rsp_error       = rsp_valid && !in_range;
    assign rsp_rdata       = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_jailbreak_hs_ctrl.sv
// Bench for jailbreak_hs_ctrl: a core RAM model with two-cycle read latency plus a
// transaction-level timing/data model derived from when the last response occurred.
module tb_jailbreak_hs_ctrl;

    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int HS_SIZE = 256;
    localparam int SETTLE  = 64;
    localparam int RL      = 2;
    localparam int HOLD    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic          processor_halt, hs_access_write, hs_write_enable;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic [DW-1:0] hs_data_out = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rsp = -1000;

    logic [DW-1:0] core_mem [0:4095];
    logic [DW-1:0] exp_mem  [0:4095];
    logic [DW-1:0] rd_pipe;

    jailbreak_hs_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HS_SIZE(HS_SIZE),
        .SETTLE_CYCLES(SETTLE), .READ_LATENCY(RL), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .processor_halt(processor_halt), .hs_access_write(hs_access_write),
        .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write_enable(hs_write_enable), .hs_data_out(hs_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core RAM: write on strobe, read data valid two cycles after the address.
    always @(posedge clk) begin
        if (hs_access_write && hs_write_enable) core_mem[hs_address] <= hs_data_in;
        rd_pipe     <= core_mem[hs_address];
        hs_data_out <= rd_pipe;
    end

    always @(negedge clk) begin
        n_checks++;
        if ((hs_write_enable && !hs_access_write) || (hs_access_write && !processor_halt)) begin
            n_fail++;
            $display("FAIL invariant: we=%0b sel=%0b halt=%0b, required we->sel and sel->halt",
                     hs_write_enable, hs_access_write, processor_halt);
        end
    end

    // One request from the current negedge to its response negedge.
    task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit keep);
        int n, exp_lat, acc_at, we_cnt, hcyc, exp_acc;
        bit from_hold, err;
        logic [DW-1:0] exp_rd;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        hcyc      = cyc;
        from_hold = (hcyc - last_rsp) <= HOLD;
        err       = int'(a) >= HS_SIZE;
        exp_lat   = (from_hold ? 0 : SETTLE) + ((w || err) ? 2 : 2 + RL);
        exp_acc   = (from_hold ? 0 : SETTLE) + 1;
        exp_rd    = (w || err) ? '0 : exp_mem[a];
        n_checks++;
        if (processor_halt !== from_hold) begin
            n_fail++;
            $display("FAIL halt_at_accept: halt=%0b, required %0b", processor_halt, from_hold);
        end
        acc_at = -1; we_cnt = 0;
        for (n = 1; n <= exp_lat + 20; n++) begin
            @(negedge clk);
            if (n == 1 && !keep) req_valid = 1'b0;
            if (hs_write_enable) we_cnt++;
            if (hs_access_write && acc_at < 0) begin
                acc_at = n;
                n_checks++;
                if (hs_address !== a) begin
                    n_fail++;
                    $display("FAIL hs_address: got %h, required %h", hs_address, a);
                end
            end
            n_checks++;
            if (processor_halt !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_busy: halt=%0b at cycle %0d of request, required 1",
                         processor_halt, n);
            end
            if (rsp_valid) break;
        end
        n_checks++;
        if (!rsp_valid) begin
            n_fail++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required at %0d",
                     exp_lat + 20, exp_lat);
            return;
        end
        n_checks++;
        if (n != exp_lat) begin
            n_fail++;
            $display("FAIL latency: got %0d, required %0d (addr %h w=%0b)", n, exp_lat, a, w);
        end
        n_checks++;
        if (rsp_error !== err) begin
            n_fail++;
            $display("FAIL rsp_error: got %0b, required %0b (addr %h)", rsp_error, err, a);
        end
        n_checks++;
        if (rsp_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL rsp_rdata: got %h, required %h (addr %h)", rsp_rdata, exp_rd, a);
        end
        n_checks++;
        if (we_cnt != ((w && !err) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL we_pulses: got %0d, required %0d", we_cnt, (w && !err) ? 1 : 0);
        end
        n_checks++;
        if (acc_at != (err ? -1 : exp_acc)) begin
            n_fail++;
            $display("FAIL access_cycle: got %0d, required %0d", acc_at, err ? -1 : exp_acc);
        end
        if (w && !err) exp_mem[a] = d;
        last_rsp = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata, processor_halt, hs_access_write,
             hs_address, hs_data_in, hs_write_enable} !== '0) begin
            n_fail++;
            $display("FAIL %s: rdy=%0b rv=%0b re=%0b rd=%h halt=%0b sel=%0b a=%h di=%h we=%0b, required all 0",
                     tag, req_ready, rsp_valid, rsp_error, rsp_rdata, processor_halt,
                     hs_access_write, hs_address, hs_data_in, hs_write_enable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || processor_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: ready=%0b halt=%0b, required 1/0", req_ready, processor_halt);
        end
        @(negedge clk);
    endtask

    task automatic test_read_idle();
        run_req(1'b0, 12'h010, 8'h00, 1'b0);
        for (int k = 1; k <= HOLD + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (processor_halt !== (k <= HOLD)) begin
                n_fail++;
                $display("FAIL halt_release: halt=%0b at %0d after rsp, required %0b",
                         processor_halt, k, k <= HOLD);
            end
        end
    endtask

    task automatic test_write_then_read();
        run_req(1'b1, 12'h020, 8'hA5, 1'b0);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (processor_halt !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_gap: halt=%0b, required 1", processor_halt);
            end
        end
        run_req(1'b0, 12'h020, 8'h00, 1'b0);
        n_checks++;
        if (exp_mem[12'h020] !== 8'hA5) begin
            n_fail++;
            $display("FAIL model_wr: model holds %h, required a5", exp_mem[12'h020]);
        end
    endtask

    task automatic test_out_of_range();
        run_req(1'b0, 12'h100, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++)
            run_req(1'($urandom), 12'($urandom_range(256, 4095)), 8'($urandom), 1'b0);
        run_req(1'b0, 12'($urandom_range(0, 255)), 8'h00, 1'b0);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 256; i++) run_req(1'b1, 12'(i), 8'($urandom), 1'b1);
        for (int i = 0; i < 256; i++) run_req(1'b0, 12'(i), 8'h00, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic test_reset_rdwait();
        int n;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h005;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); req_valid = 1'b0; n++; end
        while (!hs_access_write && n < 100);
        n_checks++;
        if (!hs_access_write) begin
            n_fail++;
            $display("FAIL rdwait_reach: sel=%0b after %0d cycles, required 1", hs_access_write, n);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_rdwait");
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || processor_halt !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset: rv=%0b halt=%0b, required 0/0", rsp_valid, processor_halt);
            end
        end
        last_rsp = -1000;
        run_req(1'b0, 12'h005, 8'h00, 1'b0);
    endtask

    task automatic test_hold_boundary();
        int gaps [0:9];
        gaps[0] = 7; gaps[1] = 8; gaps[2] = 7; gaps[3] = 8;
        for (int i = 4; i < 10; i++) gaps[i] = $urandom_range(0, 12);
        run_req(1'b1, 12'($urandom_range(0, 255)), 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            for (int k = 1; k <= gaps[i]; k++) begin
                @(negedge clk);
                n_checks++;
                if (processor_halt !== (k <= HOLD)) begin
                    n_fail++;
                    $display("FAIL hold_gap: halt=%0b at idle %0d of gap %0d, required %0b",
                             processor_halt, k, gaps[i], k <= HOLD);
                end
            end
            @(negedge clk);
            run_req(1'($urandom), 12'($urandom_range(0, 300)), 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            core_mem[i] = 8'($urandom);
            exp_mem[i]  = core_mem[i];
        end
        @(negedge clk);
        test_reset();
        test_read_idle();
        test_write_then_read();
        test_out_of_range();
        test_burst();
        test_reset_rdwait();
        test_hold_boundary();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
